// File: rtl/serial_frame_feeder_if.sv
// rtl/serial_frame_feeder_if.sv - word handshake and serial-bit bundle between source, feeder and detector
interface serial_frame_feeder_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic             x_out;
  logic             x_valid;
  logic             busy;
  logic             frame_done;

  modport master (
    output din, din_valid,
    input  din_ready, x_out, x_valid, busy, frame_done
  );

  modport slave (
    input  din, din_valid,
    output din_ready, x_out, x_valid, busy, frame_done
  );
endinterface

// File: rtl/serial_frame_feeder.sv
// rtl/serial_frame_feeder.sv - parallel-in/serial-out feeder for the pattern detector x input
// Optional even-parity trailer bit: define SERIAL_FEEDER_PARITY_EN.
module serial_frame_feeder #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input logic                  clk,
  input logic                  rst,
  serial_frame_feeder_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT
`ifdef SERIAL_FEEDER_PARITY_EN
    , ST_PARITY
`endif
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic             x_out_q, x_out_d;
`ifdef SERIAL_FEEDER_PARITY_EN
  logic             par_q, par_d;
`endif

  logic data_last;
  logic frame_last;
  logic xfer;

  function automatic logic [WIDTH-1:0] shift_word(input logic [WIDTH-1:0] w);
    return (MSB_FIRST != 0) ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
  endfunction

  function automatic logic head_bit(input logic [WIDTH-1:0] w);
    return (MSB_FIRST != 0) ? w[WIDTH-1] : w[0];
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      x_out_q <= IDLE_BIT;
`ifdef SERIAL_FEEDER_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      x_out_q <= x_out_d;
`ifdef SERIAL_FEEDER_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  // x_out_d always carries the bit for the next cycle, so x_out leaves a flop.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    x_out_d = x_out_q;
`ifdef SERIAL_FEEDER_PARITY_EN
    par_d   = par_q;
`endif
    if (xfer) begin
      state_d = ST_SHIFT;
      cnt_d   = '0;
      sh_d    = bus.din;
      x_out_d = head_bit(bus.din);
`ifdef SERIAL_FEEDER_PARITY_EN
      par_d   = ^bus.din;
`endif
    end else if (frame_last) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      sh_d    = '0;
      x_out_d = IDLE_BIT;
    end
`ifdef SERIAL_FEEDER_PARITY_EN
    else if (data_last) begin
      state_d = ST_PARITY;
      x_out_d = par_q;
    end
`endif
    else if (state_q == ST_SHIFT) begin
      cnt_d   = cnt_q + 1'b1;
      sh_d    = shift_word(sh_q);
      x_out_d = head_bit(shift_word(sh_q));
    end
  end

  always_comb begin
    data_last = (state_q == ST_SHIFT) && (cnt_q == CNT_LAST);
`ifdef SERIAL_FEEDER_PARITY_EN
    frame_last = (state_q == ST_PARITY);
`else
    frame_last = data_last;
`endif
    // rst gates ready combinationally because the reset state itself is IDLE.
    bus.din_ready  = !rst && ((state_q == ST_IDLE) || frame_last);
    bus.x_valid    = (state_q != ST_IDLE);
    bus.busy       = (state_q != ST_IDLE);
    bus.frame_done = frame_last;
    bus.x_out      = x_out_q;
    xfer           = bus.din_valid && bus.din_ready;
  end
endmodule

// File: tb/tb_serial_frame_feeder.sv
// tb/tb_serial_frame_feeder.sv - directed bench for serial_frame_feeder
// Uses SERIAL_FEEDER_PARITY_EN to pick frame length and parity expectations.
module tb_serial_frame_feeder;
`ifdef SERIAL_FEEDER_PARITY_EN
  localparam int FL = 9;
`else
  localparam int FL = 8;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  serial_frame_feeder_if #(.WIDTH(8)) ifm ();
  serial_frame_feeder_if #(.WIDTH(8)) ifl ();

  serial_frame_feeder #(.WIDTH(8), .MSB_FIRST(1), .IDLE_BIT(1'b0)) dut_m (
    .clk(clk), .rst(rst), .bus(ifm)
  );
  serial_frame_feeder #(.WIDTH(8), .MSB_FIRST(0), .IDLE_BIT(1'b0)) dut_l (
    .clk(clk), .rst(rst), .bus(ifl)
  );

  typedef struct {
    logic [7:0] din;
    logic [0:7] seq;
    logic       par;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_idle(input string name);
    chk({name, " idle x_valid"}, 32'(ifm.x_valid), 32'd0);
    chk({name, " idle x_out"}, 32'(ifm.x_out), 32'd0);
    chk({name, " idle busy"}, 32'(ifm.busy), 32'd0);
    chk({name, " idle frame_done"}, 32'(ifm.frame_done), 32'd0);
    chk({name, " idle din_ready"}, 32'(ifm.din_ready), 32'd1);
  endtask

  // Called on the negedge inside bit cycle 1; ends on the negedge after the last bit.
  task automatic check_frame(input logic [0:7] seq, input logic par, input int drop_at,
                             input int load_at, input logic [7:0] load_word, input string name);
    for (int i = 0; i < FL; i++) begin
      logic exp_bit;
      exp_bit = (i < 8) ? seq[i] : par;
      chk($sformatf("%s bit%0d x_out", name, i), 32'(ifm.x_out), 32'(exp_bit));
      chk($sformatf("%s bit%0d x_valid", name, i), 32'(ifm.x_valid), 32'd1);
      chk($sformatf("%s bit%0d busy", name, i), 32'(ifm.busy), 32'd1);
      chk($sformatf("%s bit%0d frame_done", name, i), 32'(ifm.frame_done), 32'(i == FL - 1));
      chk($sformatf("%s bit%0d din_ready", name, i), 32'(ifm.din_ready), 32'(i == FL - 1));
      if (i == drop_at) ifm.din_valid = 1'b0;
      if (i == load_at) begin
        ifm.din       = load_word;
        ifm.din_valid = 1'b1;
      end
      @(negedge clk);
    end
  endtask

  task automatic send_frame(input logic [7:0] w, input logic [0:7] seq, input logic par,
                            input string name);
    chk({name, " pre din_ready"}, 32'(ifm.din_ready), 32'd1);
    ifm.din       = w;
    ifm.din_valid = 1'b1;
    @(negedge clk);
    check_frame(seq, par, 0, -1, 8'h00, name);
    check_idle(name);
  endtask

  initial begin
    vecs[0] = '{din: 8'hD0, seq: 8'b11010000, par: 1'b1};
    vecs[1] = '{din: 8'h07, seq: 8'b00000111, par: 1'b1};
    vecs[2] = '{din: 8'h00, seq: 8'b00000000, par: 1'b0};
    vecs[3] = '{din: 8'hFF, seq: 8'b11111111, par: 1'b0};
    vecs[4] = '{din: 8'h81, seq: 8'b10000001, par: 1'b0};
    vecs[5] = '{din: 8'h96, seq: 8'b10010110, par: 1'b0};

    ifm.din = 8'h00; ifm.din_valid = 1'b0;
    ifl.din = 8'h00; ifl.din_valid = 1'b0;

    @(negedge clk);
    ifm.din = 8'hAA; ifm.din_valid = 1'b1;
    @(negedge clk);
    chk("rst x_out", 32'(ifm.x_out), 32'd0);
    chk("rst x_valid", 32'(ifm.x_valid), 32'd0);
    chk("rst busy", 32'(ifm.busy), 32'd0);
    chk("rst frame_done", 32'(ifm.frame_done), 32'd0);
    chk("rst din_ready", 32'(ifm.din_ready), 32'd0);
    ifm.din_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("post-rst din_ready", 32'(ifm.din_ready), 32'd1);
    @(negedge clk);

    for (int v = 0; v < 6; v++)
      send_frame(vecs[v].din, vecs[v].seq, vecs[v].par, $sformatf("vec%0d", v));

    // Back-to-back frames with din_valid held: no idle bit between them.
    ifm.din = 8'hA5; ifm.din_valid = 1'b1;
    @(negedge clk);
    check_frame(8'b10100101, 1'b0, -1, 0, 8'h3C, "b2b_a5");
    check_frame(8'b00111100, 1'b0, 0, -1, 8'h00, "b2b_3c");
    check_idle("b2b");

    // Word offered mid-frame waits for the last-bit cycle.
    ifm.din = 8'h55; ifm.din_valid = 1'b1;
    @(negedge clk);
    check_frame(8'b01010101, 1'b0, 0, 2, 8'hC3, "busy_55");
    check_frame(8'b11000011, 1'b0, 0, -1, 8'h00, "busy_c3");
    check_idle("busy");

    // Reset during bit 3 of 0xFF.
    ifm.din = 8'hFF; ifm.din_valid = 1'b1;
    @(negedge clk);
    ifm.din_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rstmid bit%0d x_out", i), 32'(ifm.x_out), 32'd1);
      if (i < 2) @(negedge clk);
    end
    rst = 1'b1;
    #1;
    chk("rstmid x_out", 32'(ifm.x_out), 32'd0);
    chk("rstmid x_valid", 32'(ifm.x_valid), 32'd0);
    chk("rstmid busy", 32'(ifm.busy), 32'd0);
    chk("rstmid din_ready", 32'(ifm.din_ready), 32'd0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk($sformatf("rstmid hold%0d frame_done", i), 32'(ifm.frame_done), 32'd0);
    end
    rst = 1'b0;
    #1;
    chk("rstmid release din_ready", 32'(ifm.din_ready), 32'd1);
    chk("rstmid release x_valid", 32'(ifm.x_valid), 32'd0);
    @(negedge clk);
    send_frame(8'h81, 8'b10000001, 1'b0, "after_rst");

    // LSB-first instance.
    chk("lsb idle x_out", 32'(ifl.x_out), 32'd0);
    chk("lsb idle din_ready", 32'(ifl.din_ready), 32'd1);
    ifl.din = 8'h01; ifl.din_valid = 1'b1;
    @(negedge clk);
    ifl.din_valid = 1'b0;
    for (int i = 0; i < FL; i++) begin
      chk($sformatf("lsb bit%0d x_out", i), 32'(ifl.x_out), 32'((i == 0) || (i == 8)));
      chk($sformatf("lsb bit%0d x_valid", i), 32'(ifl.x_valid), 32'd1);
      chk($sformatf("lsb bit%0d frame_done", i), 32'(ifl.frame_done), 32'(i == FL - 1));
      @(negedge clk);
    end
    chk("lsb after x_out", 32'(ifl.x_out), 32'd0);
    chk("lsb after x_valid", 32'(ifl.x_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
